pipeline_hazard_ctrl: RTL
=========================

// Module: pipeline_hazard_ctrl
// PURPOSE
//  Central stall/flush sequencer for the 5-stage MIPS pipeline. Drives load/bubble controls of PC, IF_ID,
//  ID_EX, EX_MEM and MEM_WB registers: resolves load-use hazards, taken-branch flushes, and multi-cycle
//  data-memory accesses (ready handshake with timeout). Sits beside the datapath; no data passes through it.
// PARAMETERS
//  MEM_TIMEOUT  16  max cycles in MEM_WAIT before error; legal range 2..255
//  CNT_W        16  width of the saturating performance counters
// PORTS
//  clk            in   1      pipeline clock; all state updates on rising edge
//  reset          in   1      synchronous, active-high reset
//  id_rs          in   5      rs field of instruction in ID
//  id_rt          in   5      rt field of instruction in ID
//  id_uses_rt     in   1      ID instruction reads rt (R-type, beq, sw)
//  idex_mem_read  in   1      ID_EX holds a load (MemRead bit of its M field)
//  idex_rt        in   5      destination register of the load in ID_EX
//  exmem_m        in   3      M control field held in EX_MEM: [2]=Branch, [1]=MemRead, [0]=MemWrite
//  branch_taken   in   1      branch resolved taken this cycle (from EX_MEM Branch & zero)
//  dmem_ready     in   1      data memory completes the current access this cycle
//  pc_en          out  1      PC load enable
//  ifid_en        out  1      IF_ID load enable
//  ifid_flush     out  1      IF_ID loads a NOP instead of the fetched word
//  idex_en        out  1      ID_EX load enable
//  idex_bubble    out  1      ID_EX loads all-zero control (WB/M/EX = 0)
//  exmem_en       out  1      EX_MEM load enable
//  memwb_bubble   out  1      MEM_WB loads zero WB control
//  dmem_req       out  1      data-memory access request
//  mem_err        out  1      sticky timeout error
//  stall_cnt      out  CNT_W  cycles with pc_en=0 (saturating)
//  flush_cnt      out  CNT_W  taken-branch flushes (saturating)
// BEHAVIOUR
//  Reset (sync, high): state=RUN, wait_cnt=0, mem_err=0, stall_cnt=0, flush_cnt=0. While reset is high,
//   all enables=0, ifid_flush=1, idex_bubble=1, memwb_bubble=1, dmem_req=0. Reset mid-MEM_WAIT or in
//   MEM_ERR returns to RUN with no residual request.
//  Control outputs are combinational from (state, inputs); state/counters are registered; 0-cycle latency.
//  mem_op = exmem_m[1] | exmem_m[0]; dmem_req = mem_op & (state==RUN | state==MEM_WAIT).
//  load_use = idex_mem_read & idex_rt!=0 & (idex_rt==id_rs | (id_uses_rt & idex_rt==id_rt)).
//  States: RUN, MEM_WAIT, MEM_ERR. Priority per cycle: reset > memory stall > branch flush > load-use.
//  RUN:
//   mem_op & !dmem_ready -> freeze: all *_en=0, memwb_bubble=1, no flush; wait_cnt<=1; ->MEM_WAIT.
//   else branch_taken -> all en=1, ifid_flush=1, idex_bubble=1; flush_cnt++; stay RUN.
//   else load_use -> pc_en=0, ifid_en=0, idex_bubble=1, idex_en=1, exmem_en=1; stay RUN (1 bubble).
//   else all en=1, no flush/bubble.
//  MEM_WAIT: dmem_ready -> outputs identical to RUN evaluated this cycle excluding the memory-stall term
//   (branch/load-use still apply); wait_cnt<=0; ->RUN.
//   !dmem_ready & wait_cnt==MEM_TIMEOUT-1 -> freeze; mem_err<=1; ->MEM_ERR. else freeze; wait_cnt++.
//   branch_taken/load_use arriving during a freeze are held by frozen regs and acted on at release.
//  MEM_ERR: terminal until reset; freeze outputs, dmem_req=0, mem_err=1.
//  Counters: stall_cnt++ each cycle pc_en=0 outside reset; both saturate at 2^CNT_W-1, never wrap.
//  wait_cnt width = $clog2(MEM_TIMEOUT+1).
// STRUCTURE
//  Package pipe_ctrl_pkg: M-field bit indices (M_BRANCH=2, M_MEMREAD=1, M_MEMWRITE=0), state enum
//   {RUN, MEM_WAIT, MEM_ERR}, REG_ZERO=5'd0. Shared with the ID_EX/EX_MEM control encoding.
//  Sub-module load_use_detect: combinational comparator producing load_use; FSM and counters stay here.
// TESTING
//  1 lw $t0 in ID_EX (idex_rt=8), ID add uses rs=8 -> one cycle pc_en=0,ifid_en=0,idex_bubble=1; next RUN.
//  2 idex_rt=0 with id_rs=0 and idex_mem_read=1 -> no stall; all en=1.
//  3 exmem_m=3'b010, dmem_ready low 3 cycles then high -> 3 frozen cycles, release on 4th, stall_cnt=3.
//  4 dmem_ready never high, MEM_TIMEOUT=16 -> mem_err=1 after 16 frozen cycles; reset clears all to 0.
//  5 branch_taken with load_use same cycle -> ifid_flush=1, idex_bubble=1, pc_en=1, flush_cnt=1.
//  6 CNT_W=4, 20 load-use stalls -> stall_cnt holds at 15; reset asserted in MEM_WAIT -> RUN, dmem_req=0.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared M-field encoding and sequencer state type for the pipeline controls
package pipe_ctrl_pkg;

  localparam int M_BRANCH   = 2;
  localparam int M_MEMREAD  = 1;
  localparam int M_MEMWRITE = 0;

  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    MEM_ERR  = 2'd2
  } ctrl_state_e;

endpackage

// File: rtl/load_use_detect.sv
// rtl/load_use_detect.sv - flags an ID instruction reading the destination of a load still in ID_EX
module load_use_detect
  import pipe_ctrl_pkg::*;
(
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_uses_rt,
  input  logic       idex_mem_read,
  input  logic [4:0] idex_rt,
  output logic       load_use
);

  // $zero is never a real dependency, so a load targeting it never stalls.
  always_comb begin
    load_use = idex_mem_read && (idex_rt != REG_ZERO) &&
               ((idex_rt == id_rs) || (id_uses_rt && (idex_rt == id_rt)));
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - stall/flush sequencer for the 5-stage pipeline registers
module pipeline_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rt,
  input  logic             idex_mem_read,
  input  logic [4:0]       idex_rt,
  input  logic [2:0]       exmem_m,
  input  logic             branch_taken,
  input  logic             dmem_ready,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             ifid_flush,
  output logic             idex_en,
  output logic             idex_bubble,
  output logic             exmem_en,
  output logic             memwb_bubble,
  output logic             dmem_req,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  ctrl_state_e       state;
  logic [WAIT_W-1:0] wait_cnt;
  logic              mem_op;
  logic              load_use;
  logic              freeze;
  logic              branch_flush;
  logic              branch_bit_unused;

  // The Branch bit is already folded into branch_taken upstream.
  assign branch_bit_unused = exmem_m[M_BRANCH];
  assign mem_op = exmem_m[M_MEMREAD] | exmem_m[M_MEMWRITE];

  load_use_detect u_load_use_detect (
    .id_rs         (id_rs),
    .id_rt         (id_rt),
    .id_uses_rt    (id_uses_rt),
    .idex_mem_read (idex_mem_read),
    .idex_rt       (idex_rt),
    .load_use      (load_use)
  );

  always_comb begin
    pc_en        = 1'b1;
    ifid_en      = 1'b1;
    idex_en      = 1'b1;
    exmem_en     = 1'b1;
    ifid_flush   = 1'b0;
    idex_bubble  = 1'b0;
    memwb_bubble = 1'b0;
    dmem_req     = 1'b0;
    freeze       = 1'b0;
    branch_flush = 1'b0;
    if (reset) begin
      pc_en        = 1'b0;
      ifid_en      = 1'b0;
      idex_en      = 1'b0;
      exmem_en     = 1'b0;
      ifid_flush   = 1'b1;
      idex_bubble  = 1'b1;
      memwb_bubble = 1'b1;
    end else begin
      case (state)
        RUN: begin
          freeze   = mem_op && !dmem_ready;
          dmem_req = mem_op;
        end
        MEM_WAIT: begin
          freeze   = !dmem_ready;
          dmem_req = mem_op;
        end
        default: freeze = 1'b1;
      endcase
      // A freeze holds every register, so pending branch/load-use resolve on release.
      if (freeze) begin
        pc_en        = 1'b0;
        ifid_en      = 1'b0;
        idex_en      = 1'b0;
        exmem_en     = 1'b0;
        memwb_bubble = 1'b1;
      end else if (branch_taken) begin
        ifid_flush   = 1'b1;
        idex_bubble  = 1'b1;
        branch_flush = 1'b1;
      end else if (load_use) begin
        pc_en        = 1'b0;
        ifid_en      = 1'b0;
        idex_bubble  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= RUN;
      wait_cnt  <= '0;
      mem_err   <= 1'b0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      case (state)
        RUN: begin
          if (freeze) begin
            wait_cnt <= WAIT_W'(1);
            state    <= MEM_WAIT;
          end
        end
        MEM_WAIT: begin
          if (dmem_ready) begin
            wait_cnt <= '0;
            state    <= RUN;
          end else if (wait_cnt == WAIT_LAST) begin
            mem_err  <= 1'b1;
            state    <= MEM_ERR;
          end else begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
          end
        end
        MEM_ERR: ;
        default: state <= RUN;
      endcase
      if (!pc_en && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_W'(1);
      if (branch_flush && (flush_cnt != '1)) flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

endmodule
